// File: rtl/az_isa_pkg.sv
// Shared ISA definitions for the stack-machine front end: opcodes, fetch/decode
// states and instruction-word field layout.
package az_isa_pkg;

  // Instruction word = {opcode[OPC_W-1:0], operand[DATA_LEN-1:0]}
  localparam int OPC_W   = 4;
  localparam int OPR_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_PUSH  = 4'h1;
  localparam logic [OPC_W-1:0] OP_POP   = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR    = 4'h6;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'h7;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h8;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h9;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'hA;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'hB;
  localparam logic [OPC_W-1:0] OP_CALL  = 4'hC;
  localparam logic [OPC_W-1:0] OP_NXTI  = 4'hD;
  localparam logic [OPC_W-1:0] OP_EXIT  = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STEP  = 3'd4,
    ST_HALT  = 3'd5,
    ST_FAULT = 3'd6
  } fd_state_e;

endpackage

// File: rtl/inst_store.sv
// Instruction store: INST_CAP x INST_LEN register array, one synchronous write
// port and one asynchronous read port. Out-of-range addresses are inert.
module inst_store #(
  parameter int INST_CAP = 20,
  parameter int INST_LEN = 12,
  parameter int PC_W     = $clog2(INST_CAP) + 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [PC_W-1:0]     wr_addr,
  input  logic [INST_LEN-1:0] wr_data,
  input  logic [PC_W-1:0]     rd_addr,
  output logic [INST_LEN-1:0] rd_data
);

  localparam int              AW  = $clog2(INST_CAP);
  localparam logic [PC_W-1:0] CAP = PC_W'(INST_CAP);

  logic [INST_LEN-1:0] mem [INST_CAP];

  // NOTE: the array has no reset; program contents survive rstn and are only
  // changed by explicit writes, which keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (we && (wr_addr < CAP)) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = (rd_addr < CAP) ? mem[rd_addr[AW-1:0]] : '0;

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: reads mem[pc], issues opcode/operand with a one-cycle en
// pulse, then waits EXEC_LAT cycles. Optional single-step mode: FETCH_STEP_EN.
module fetch_decode
  import az_isa_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int INST_CAP = 20,
  parameter int EXEC_LAT = 3,
  parameter int PC_W     = $clog2(INST_CAP) + 1,
  parameter int INST_LEN = OPC_W + DATA_LEN
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
`ifdef FETCH_STEP_EN
  input  logic                step,
`endif
  input  logic                prog_we,
  input  logic [PC_W-1:0]     prog_addr,
  input  logic [INST_LEN-1:0] prog_data,
  input  logic [PC_W-1:0]     pc,
  output logic                en,
  output logic [OPC_W-1:0]    control_bus,
  output logic [DATA_LEN-1:0] addr_const,
  output logic                busy,
  output logic                halted,
  output logic                fault
);

  localparam int               CNT_W    = $clog2(EXEC_LAT) + 1;
  localparam logic [PC_W-1:0]  CAP      = PC_W'(INST_CAP);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_LAT - 1);

  fd_state_e           state_q, state_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                en_q, en_d;
  logic                busy_q, halted_q, fault_q;
  logic [INST_LEN-1:0] rd_data;
  logic                store_we;

  // The store is writable only while the machine is parked.
  assign store_we = prog_we && (state_q inside {ST_IDLE, ST_HALT, ST_FAULT});

  inst_store #(
    .INST_CAP (INST_CAP),
    .INST_LEN (INST_LEN),
    .PC_W     (PC_W)
  ) u_store (
    .clk     (clk),
    .we      (store_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path through
    // the case leaves one unassigned and infers a latch.
    state_d = state_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT, ST_FAULT: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (pc >= CAP) begin
          state_d = ST_FAULT;
        end else begin
          inst_d  = rd_data;
          state_d = ST_ISSUE;
          // en is registered, so the ISSUE-cycle strobe is decided here
          en_d    = (rd_data[INST_LEN-1 -: OPC_W] != OP_HALT);
        end
      end
      ST_ISSUE: begin
        if (inst_q[INST_LEN-1 -: OPC_W] == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
`ifdef FETCH_STEP_EN
          state_d = ST_STEP;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STEP: begin
`ifdef FETCH_STEP_EN
        if (step) state_d = ST_FETCH;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      inst_q   <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      busy_q   <= state_d inside {ST_FETCH, ST_ISSUE, ST_WAIT, ST_STEP};
      halted_q <= (state_d == ST_HALT);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign en          = en_q;
  assign control_bus = inst_q[INST_LEN-1 -: OPC_W];
  assign addr_const  = inst_q[OPR_LSB +: DATA_LEN];
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: hand vectors, corner sequences and
// randomized programs against a program-level reference model.
module tb_fetch_decode;
  import az_isa_pkg::*;

  localparam int DATA_LEN = 8;
  localparam int INST_CAP = 20;
  localparam int EXEC_LAT = 3;
  localparam int PC_W     = 6;
  localparam int INST_LEN = 12;
`ifdef FETCH_STEP_EN
  localparam int P = EXEC_LAT + 4;   // one extra STEP cycle held before step
`else
  localparam int P = EXEC_LAT + 2;
`endif
  localparam int BUDGET = P * (INST_CAP + 2) + 10;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
`ifdef FETCH_STEP_EN
  logic                step = 1'b0;
`endif
  logic                prog_we = 1'b0;
  logic [PC_W-1:0]     prog_addr = '0;
  logic [INST_LEN-1:0] prog_data = '0;
  logic [PC_W-1:0]     pc = '0;
  logic                en;
  logic [3:0]          control_bus;
  logic [DATA_LEN-1:0] addr_const;
  logic                busy, halted, fault;

  fetch_decode #(
    .DATA_LEN (DATA_LEN),
    .INST_CAP (INST_CAP),
    .EXEC_LAT (EXEC_LAT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
`ifdef FETCH_STEP_EN
    .step        (step),
`endif
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .pc          (pc),
    .en          (en),
    .control_bus (control_bus),
    .addr_const  (addr_const),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [INST_LEN-1:0] mem_m [INST_CAP];
  logic [3:0]          exp_op[$], got_op[$];
  logic [7:0]          exp_c[$],  got_c[$];

  typedef struct {
    logic [PC_W-1:0]     base;
    logic [INST_LEN-1:0] w0, w1, w2;
    int                  exp_n;
    logic [3:0]          op0;
    logic [7:0]          c0;
    bit                  h;
    bit                  f;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [PC_W-1:0] a, input logic [INST_LEN-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
    if (a < INST_CAP) mem_m[a] = d;
  endtask

  // Program-level model: walk pc upward until HALT or out of range.
  task automatic model(input logic [PC_W-1:0] spc, output int n, output bit h, output bit f);
    int p;
    p = int'(spc);
    n = 0; h = 1'b0; f = 1'b0;
    exp_op.delete();
    exp_c.delete();
    while (1) begin
      if (p >= INST_CAP) begin f = 1'b1; break; end
      if (mem_m[p][11:8] == 4'hF) begin h = 1'b1; break; end
      exp_op.push_back(mem_m[p][11:8]);
      exp_c.push_back(mem_m[p][7:0]);
      n++;
      p++;
    end
  endtask

  // Acts as the execute stage: advances pc after each en, optionally pokes
  // the store during WAIT, always tries a stray start during WAIT.
  task automatic run(input logic [PC_W-1:0] spc, input bit wait_we,
                     input bit same_we, input logic [PC_W-1:0] swa,
                     input logic [INST_LEN-1:0] swd,
                     output int n, output bit h, output bit f, output int t,
                     output bit timing_ok, output bit stable_ok, output bit done);
    int last_en;
    pc = spc;
    got_op.delete();
    got_c.delete();
    if (same_we) begin
      prog_we = 1'b1; prog_addr = swa; prog_data = swd;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    prog_we = 1'b0;
    t = 1; n = 0; h = 0; f = 0; done = 0;
    timing_ok = 1; stable_ok = 1; last_en = -100;
    while (!done && t < BUDGET) begin
      if (en) begin
        if (t != 2 + P * n) timing_ok = 0;
        got_op.push_back(control_bus);
        got_c.push_back(addr_const);
        n++;
        last_en = t;
        pc = pc + 1'b1;
      end else if (t > last_en && t <= last_en + EXEC_LAT) begin
        if (control_bus !== got_op[$] || addr_const !== got_c[$] || !busy) stable_ok = 0;
      end
      if (halted) h = 1;
      if (fault) f = 1;
      if (h || f) done = 1;
      prog_we   = wait_we && (t == 3);
      prog_addr = '0;
      prog_data = 12'hF00;
      start     = (t == 4);
`ifdef FETCH_STEP_EN
      step      = (n > 0) && (t == last_en + EXEC_LAT + 2);
`endif
      if (!done) begin
        tick();
        t++;
      end
    end
    prog_we = 1'b0;
    start   = 1'b0;
`ifdef FETCH_STEP_EN
    step    = 1'b0;
`endif
  endtask

  task automatic run_and_check(input string tag, input logic [PC_W-1:0] spc,
                               input bit wait_we_req, input bit same_we,
                               input logic [PC_W-1:0] swa, input logic [INST_LEN-1:0] swd,
                               output int n, output bit h, output bit f);
    int en_n, t;
    bit eh, ef, tok, sok, done, wait_we;
    if (same_we && swa < INST_CAP) mem_m[swa] = swd;
    model(spc, en_n, eh, ef);
    wait_we = wait_we_req && (en_n > 0);
    run(spc, wait_we, same_we, swa, swd, n, h, f, t, tok, sok, done);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".n_en"}, n, en_n);
    check({tag, ".halted"}, 32'(h), 32'(eh));
    check({tag, ".fault"}, 32'(f), 32'(ef));
    check({tag, ".end_t"}, t, eh ? 3 + P * en_n : 2 + P * en_n);
    check({tag, ".timing"}, 32'(tok), 32'd1);
    check({tag, ".stable"}, 32'(sok), 32'd1);
    for (int i = 0; i < en_n; i++) begin
      check($sformatf("%s.op%0d", tag, i), (i < got_op.size()) ? 32'(got_op[i]) : 32'hx, 32'(exp_op[i]));
      check($sformatf("%s.c%0d", tag, i), (i < got_c.size()) ? 32'(got_c[i]) : 32'hx, 32'(exp_c[i]));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  h, f;
    logic [INST_LEN-1:0] d;

    vecs[0] = '{base: 6'd0,  w0: 12'h342, w1: 12'h107, w2: 12'hF00, exp_n: 2, op0: 4'h3, c0: 8'h42, h: 1, f: 0};
    vecs[1] = '{base: 6'd17, w0: 12'h211, w1: 12'h522, w2: 12'h633, exp_n: 3, op0: 4'h2, c0: 8'h11, h: 0, f: 1};
    vecs[2] = '{base: 6'd5,  w0: 12'hFAA, w1: 12'h101, w2: 12'h102, exp_n: 0, op0: 4'h0, c0: 8'h00, h: 1, f: 0};
    vecs[3] = '{base: 6'd20, w0: 12'h111, w1: 12'h222, w2: 12'h333, exp_n: 0, op0: 4'h0, c0: 8'h00, h: 0, f: 1};
    vecs[4] = '{base: 6'd10, w0: 12'hD01, w1: 12'hE02, w2: 12'hF00, exp_n: 2, op0: 4'hD, c0: 8'h01, h: 1, f: 0};

    rstn = 1'b0;
    tick();
    tick();
    check("rst.en", 32'(en), 0);
    check("rst.control_bus", 32'(control_bus), 0);
    check("rst.addr_const", 32'(addr_const), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.halted", 32'(halted), 0);
    check("rst.fault", 32'(fault), 0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < INST_CAP; i++) begin
      d = {4'($urandom_range(0, 14)), 8'($urandom)};
      prog_write(6'(i), d);
    end

    for (int v = 0; v < 5; v++) begin
      prog_write(vecs[v].base,        vecs[v].w0);
      prog_write(vecs[v].base + 6'd1, vecs[v].w1);
      prog_write(vecs[v].base + 6'd2, vecs[v].w2);
      run_and_check($sformatf("vec%0d", v), vecs[v].base, 0, 0, '0, '0, n, h, f);
      check($sformatf("vec%0d.hand_n", v), n, vecs[v].exp_n);
      check($sformatf("vec%0d.hand_h", v), 32'(h), 32'(vecs[v].h));
      check($sformatf("vec%0d.hand_f", v), 32'(f), 32'(vecs[v].f));
      if (vecs[v].exp_n > 0) begin
        check($sformatf("vec%0d.hand_op0", v), (got_op.size() > 0) ? 32'(got_op[0]) : 32'hx, 32'(vecs[v].op0));
        check($sformatf("vec%0d.hand_c0", v), (got_c.size() > 0) ? 32'(got_c[0]) : 32'hx, 32'(vecs[v].c0));
      end
    end

    // Store write during WAIT must be dropped; the rerun still sees 3_42.
    run_and_check("waitwe", 6'd0, 1, 0, '0, '0, n, h, f);
    run_and_check("waitwe_rerun", 6'd0, 0, 0, '0, '0, n, h, f);
    check("waitwe_rerun.op0", (got_op.size() > 0) ? 32'(got_op[0]) : 32'hx, 32'h3);
    check("waitwe_rerun.c0", (got_c.size() > 0) ? 32'(got_c[0]) : 32'hx, 32'h42);

    // start and prog_we in the same parked cycle: FETCH sees the new word.
    run_and_check("samewe", 6'd0, 0, 1, 6'd0, 12'h65A, n, h, f);
    check("samewe.op0", (got_op.size() > 0) ? 32'(got_op[0]) : 32'hx, 32'h6);
    check("samewe.c0", (got_c.size() > 0) ? 32'(got_c[0]) : 32'hx, 32'h5A);
    prog_write(6'd0, 12'h342);

    // Reset asserted during WAIT.
    pc = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("midrst.en_issue", 32'(en), 1);
    tick();
    rstn = 1'b0;
    tick();
    check("midrst.en", 32'(en), 0);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.control_bus", 32'(control_bus), 0);
    check("midrst.addr_const", 32'(addr_const), 0);
    check("midrst.halted", 32'(halted), 0);
    check("midrst.fault", 32'(fault), 0);
    rstn = 1'b1;
    tick();
    run_and_check("midrst_rerun", 6'd0, 0, 0, '0, '0, n, h, f);
    check("midrst_rerun.n", n, 2);

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        d = {(($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14))), 8'($urandom)};
        prog_write(6'($urandom_range(0, 23)), d);
      end
      run_and_check($sformatf("rnd%0d", it), 6'($urandom_range(0, 21)),
                    bit'($urandom_range(0, 1)), 0, '0, '0, n, h, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
